geofence_scheduler: RTL and testbench
=====================================

Name: geofence_scheduler

Overview:
- Sequencing controller for the geofence point-in-hexagon core. It stores one 6-vertex fence and queues tagged query points in a small FIFO.
- For each query it releases the core from reset and streams the object plus six vertices on the core's X/Y bus. It then waits for the core's valid pulse and returns a tagged result through a valid/ready output.
- It guards against a hung core with a timeout, and parks the core in reset while idle.

Parameters:
- CW, 10, coordinate width (core X/Y width).
- QD, 4, query FIFO depth (power of 2, at least 2).
- TW, 4, query tag width.
- TIMEOUT, 127, maximum WAIT cycles before a result is forced.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- fence_we  in  1  vertex write strobe
- fence_idx  in  3  vertex index 0..5; 6 and 7 are ignored
- fence_x, fence_y  in  CW each  vertex coordinates
- fence_ok  out  1  all six vertices written since reset
- fence_err  out  1  one-cycle pulse: write rejected because the block is busy or the index is invalid
- q_valid  in  1  query request
- q_ready  out  1  FIFO not full
- q_x, q_y  in  CW each  object point
- q_tag  in  TW  query tag
- core_reset  out  1  active-high reset to the core, registered
- core_X, core_Y  out  CW each  registered coordinate stream to the core
- core_valid  in  1  core result strobe
- core_is_inside  in  1  core result
- r_valid  out  1  result available
- r_ready  in  1  result accepted
- r_tag  out  TW  tag of the query
- r_inside  out  1  point is inside the fence
- r_timeout  out  1  core did not answer within TIMEOUT cycles

Behaviour:
- Reset values:
  - core_reset = 1.
  - core_X, core_Y, r_valid, r_tag, r_inside, r_timeout, fence_ok, fence_err = 0.
  - FIFO is empty; vertex-written mask is 0; FSM is IDLE.
- Reset applied mid-operation aborts everything. FIFO contents and the fence are lost; fence_ok returns to 0.
- Fence writes:
  - Accepted only in IDLE with idx < 6.
  - Accepted writes set the corresponding mask bit; fence_ok = &mask.
  - Any other write pulses fence_err for one cycle and changes no state.
- Query FIFO:
  - Push on q_valid && q_ready; q_ready = !full.
  - A push into a full FIFO is impossible by handshake.
  - Pop and push in the same cycle are both honoured.
- FSM states: IDLE, FEED, WAIT, RESULT.
- IDLE:
  - core_reset = 1.
  - If FIFO is not empty and fence_ok = 1: pop into obj/tag registers, clear core_reset at the same edge, feed_cnt = 0, go to FEED.
- FEED (8 cycles, feed_cnt 0..7; core samples every edge):
  - cnt 0: core_X/Y = object point.
  - cnt 1..6: core_X/Y = vertex cnt-1.
  - cnt 7: vertex 5 held (the core's 7th sample is a don't-care).
  - After cnt 7, go to WAIT with wait_cnt = 0.
  - core_X/Y are registered, so the value for cycle k is set at edge k-1. Object data must be on the bus in the first cycle core_reset is low.
- WAIT:
  - wait_cnt increments every cycle.
  - core_valid = 1: capture r_inside = core_is_inside, r_timeout = 0, r_valid = 1, core_reset = 1, go to RESULT.
  - wait_cnt == TIMEOUT without valid: r_inside = 0, r_timeout = 1, r_valid = 1, core_reset = 1, go to RESULT.
  - If core_valid arrives in the same cycle the timeout expires, core_valid wins.
- RESULT:
  - r_valid and r_tag/r_inside/r_timeout are held stable until r_ready.
  - When r_valid && r_ready: clear r_valid, go to IDLE.
  - The core stays in reset for the entire RESULT stay, and at least one cycle in total.
  - Minimum gap between two core transactions is 2 cycles of core_reset = 1.
- core_valid outside WAIT is ignored.
- Queries are processed strictly in FIFO order.
- The fence cannot change while a query is in flight; fence writes are rejected outside IDLE.
- Widths:
  - wait_cnt is wide enough for TIMEOUT.
  - feed_cnt is 3 bits.
  - FIFO pointers are log2(QD)+1 bits for the full/empty distinction.

Decomposition:
- Shared package geofence_pkg:
  - State encoding constants (IDLE/FEED/WAIT/RESULT).
  - NUM_VTX = 6 and FEED_LEN = 8.
  - Default CW (the core also uses it).
- One sub-module: geofence_qfifo, a synchronous FIFO of width 2*CW+TW and depth QD with valid/ready push and a pop strobe.

Test Plan:
- Fence write with idx 7, and a write during FEED -> fence_err pulses, fence_ok stays unchanged. Writing all six vertices in IDLE -> fence_ok = 1.
- Fence (100,100),(200,100),(250,200),(200,300),(100,300),(50,200); query (150,200) tag 3 -> core stream is obj then v0..v5; r_valid with r_tag = 3, r_inside = 1, r_timeout = 0.
- Same fence; query (10,10) tag 5 -> r_inside = 0, r_timeout = 0.
- Push 4 queries back to back -> q_ready drops at 4 entries; results come back in tag order 0,1,2,3; core_reset is high for at least 2 cycles between transactions.
- Core model never asserts valid -> exactly TIMEOUT WAIT cycles later r_valid = 1 and r_timeout = 1. The next query then completes normally.
- Hold r_ready = 0 for 20 cycles -> r_* outputs stay stable and core_reset stays 1. Asserting reset low mid-FEED -> all outputs go to reset values and fence_ok = 0.

Source files
------------

// File: rtl/geofence_pkg.sv
// geofence_pkg: shared constants and FSM encoding for the geofence scheduler.
package geofence_pkg;
  localparam int DEF_CW = 10;
  localparam int NUM_VTX = 6;
  localparam int FEED_LEN = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_WAIT, ST_RESULT} state_e;
endpackage

// File: rtl/geofence_qfifo.sv
// geofence_qfifo: synchronous query FIFO with valid/ready push and a pop strobe.
module geofence_qfifo #(
  parameter int W = 24,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         empty_o
);
  localparam int AW = $clog2(D);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_q, rd_q;
  logic [W-1:0] mem_q [D];
  logic push;
  assign push = push_valid_i && push_ready_o;
  assign empty_o = wr_q == rd_q;
  // extra pointer bit separates full from empty
  assign push_ready_o = (wr_q ^ rd_q) != {1'b1, {AW{1'b0}}};
  assign pop_data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop_i && !empty_o);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/geofence_scheduler.sv
// geofence_scheduler: feeds queued query points and a stored hexagon fence to the
// point-in-hexagon core, then returns tagged results with a hung-core timeout.
module geofence_scheduler
  import geofence_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int QD = 4,
  parameter int TW = 4,
  parameter int TIMEOUT = 127
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fence_we_i,
  input  logic [2:0]    fence_idx_i,
  input  logic [CW-1:0] fence_x_i,
  input  logic [CW-1:0] fence_y_i,
  output logic          fence_ok_o,
  output logic          fence_err_o,
  input  logic          q_valid_i,
  output logic          q_ready_o,
  input  logic [CW-1:0] q_x_i,
  input  logic [CW-1:0] q_y_i,
  input  logic [TW-1:0] q_tag_i,
  output logic          core_reset_o,
  output logic [CW-1:0] core_x_o,
  output logic [CW-1:0] core_y_o,
  input  logic          core_valid_i,
  input  logic          core_is_inside_i,
  output logic          r_valid_o,
  input  logic          r_ready_i,
  output logic [TW-1:0] r_tag_o,
  output logic          r_inside_o,
  output logic          r_timeout_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] vx_q [NUM_VTX];
  logic [CW-1:0] vy_q [NUM_VTX];
  logic [NUM_VTX-1:0] mask_q, mask_d;
  logic [2:0] feed_cnt_q, feed_cnt_d, vi;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] tag_q, tag_d, r_tag_q, r_tag_d, head_tag;
  logic [CW-1:0] core_x_q, core_x_d, core_y_q, core_y_d, head_x, head_y;
  logic [2*CW+TW-1:0] head;
  logic core_reset_q, core_reset_d, r_valid_q, r_valid_d;
  logic r_inside_q, r_inside_d, r_timeout_q, r_timeout_d, fence_err_q, fence_err_d;
  logic empty, start, done, res, fence_acc;
  geofence_qfifo #(.W(2*CW+TW), .D(QD)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (q_valid_i),
    .push_ready_o (q_ready_o),
    .push_data_i  ({q_tag_i, q_x_i, q_y_i}),
    .pop_i        (start),
    .pop_data_o   (head),
    .empty_o      (empty)
  );
  assign {head_tag, head_x, head_y} = head;
  assign fence_ok_o = &mask_q;
  assign start = state_q == ST_IDLE && !empty && fence_ok_o;
  assign done = core_valid_i || wait_cnt_q == WW'(TIMEOUT);
  assign res = state_q == ST_WAIT && done;
  assign fence_acc = fence_we_i && state_q == ST_IDLE && fence_idx_i < 3'(NUM_VTX);
  // bus is one cycle ahead of feed_cnt, so cnt k drives vertex k; the last slot repeats vertex 5
  assign vi = feed_cnt_q < 3'(NUM_VTX) ? feed_cnt_q : 3'(NUM_VTX - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FEED;
      ST_FEED:   if (feed_cnt_q == 3'(FEED_LEN - 1)) state_d = ST_WAIT;
      ST_WAIT:   if (done) state_d = ST_RESULT;
      ST_RESULT: if (r_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    core_reset_d = state_q == ST_IDLE ? !start : res ? 1'b1 : core_reset_q;
    feed_cnt_d   = state_q == ST_FEED ? feed_cnt_q + 3'd1 : 3'd0;
    wait_cnt_d   = state_q == ST_WAIT ? wait_cnt_q + WW'(1) : '0;
    core_x_d     = start ? head_x : state_q == ST_FEED ? vx_q[vi] : core_x_q;
    core_y_d     = start ? head_y : state_q == ST_FEED ? vy_q[vi] : core_y_q;
    tag_d        = start ? head_tag : tag_q;
    mask_d       = fence_acc ? mask_q | (NUM_VTX'(1) << fence_idx_i) : mask_q;
    fence_err_d  = fence_we_i && !fence_acc;
    r_valid_d    = res || (r_valid_q && !r_ready_i);
    r_tag_d      = res ? tag_q : r_tag_q;
    r_inside_d   = res ? core_valid_i && core_is_inside_i : r_inside_q;
    r_timeout_d  = res ? !core_valid_i : r_timeout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VTX; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      mask_q       <= '0;
      feed_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      tag_q        <= '0;
      core_reset_q <= 1'b1;
      core_x_q     <= '0;
      core_y_q     <= '0;
      fence_err_q  <= 1'b0;
      r_valid_q    <= 1'b0;
      r_tag_q      <= '0;
      r_inside_q   <= 1'b0;
      r_timeout_q  <= 1'b0;
    end else begin
      if (fence_acc) begin
        vx_q[fence_idx_i] <= fence_x_i;
        vy_q[fence_idx_i] <= fence_y_i;
      end
      mask_q       <= mask_d;
      feed_cnt_q   <= feed_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      tag_q        <= tag_d;
      core_reset_q <= core_reset_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      fence_err_q  <= fence_err_d;
      r_valid_q    <= r_valid_d;
      r_tag_q      <= r_tag_d;
      r_inside_q   <= r_inside_d;
      r_timeout_q  <= r_timeout_d;
    end
  end
  assign core_reset_o = core_reset_q;
  assign core_x_o     = core_x_q;
  assign core_y_o     = core_y_q;
  assign fence_err_o  = fence_err_q;
  assign r_valid_o    = r_valid_q;
  assign r_tag_o      = r_tag_q;
  assign r_inside_o   = r_inside_q;
  assign r_timeout_o  = r_timeout_q;
endmodule

// File: tb/tb_geofence_scheduler.sv
// tb_geofence_scheduler: randomized scoreboard bench with a behavioural core model
// and a ray-casting reference for point-in-hexagon results.
module tb_geofence_scheduler;
  localparam int CW = 10, QD = 4, TW = 4, TO = 20;
  typedef struct {int x; int y; int tag; int dly; int ins; bit hang;} q_t;
  logic clk, rst_n;
  logic fence_we;
  logic [2:0] fence_idx;
  logic [CW-1:0] fence_x, fence_y;
  logic fence_ok, fence_err;
  logic q_valid, q_ready;
  logic [CW-1:0] q_x, q_y;
  logic [TW-1:0] q_tag;
  logic core_reset;
  logic [CW-1:0] core_x, core_y;
  logic core_valid, core_inside;
  logic r_valid, r_ready, r_inside, r_timeout;
  logic [TW-1:0] r_tag;
  int tests = 0, fails = 0;
  bit hold = 0;
  int fx [6];
  int fy [6];
  logic [5:0] fmask = '0;
  q_t exp_q [$];
  q_t cfg_q [$];

  geofence_scheduler #(.CW(CW), .QD(QD), .TW(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fence_we_i(fence_we), .fence_idx_i(fence_idx), .fence_x_i(fence_x), .fence_y_i(fence_y),
    .fence_ok_o(fence_ok), .fence_err_o(fence_err),
    .q_valid_i(q_valid), .q_ready_o(q_ready), .q_x_i(q_x), .q_y_i(q_y), .q_tag_i(q_tag),
    .core_reset_o(core_reset), .core_x_o(core_x), .core_y_o(core_y),
    .core_valid_i(core_valid), .core_is_inside_i(core_inside),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_tag_o(r_tag),
    .r_inside_o(r_inside), .r_timeout_o(r_timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // even-odd ray casting against the bench's own fence copy
  function automatic bit pip(input int px, input int py);
    bit c = 0;
    for (int i = 0; i < 6; i++) begin
      int j = (i + 5) % 6;
      if ((fy[i] > py) != (fy[j] > py)) begin
        real xc = real'(fx[i]) + real'(fx[j] - fx[i]) * real'(py - fy[i]) / real'(fy[j] - fy[i]);
        if (real'(px) < xc) c = !c;
      end
    end
    return c;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_x", core_x, 0);
    chk("rst_core_y", core_y, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_tag", r_tag, 0);
    chk("rst_r_inside", r_inside, 0);
    chk("rst_r_timeout", r_timeout, 0);
    chk("rst_fence_ok", fence_ok, 0);
    chk("rst_fence_err", fence_err, 0);
    chk("rst_q_ready", q_ready, 1);
  endtask

  task automatic wr_fence(input int idx, input int x, input int y, input bit acc);
    @(posedge clk); #1;
    fence_we = 1; fence_idx = 3'(idx); fence_x = CW'(x); fence_y = CW'(y);
    @(posedge clk); #1;
    fence_we = 0;
    if (acc) begin
      fx[idx] = x; fy[idx] = y; fmask[idx] = 1'b1;
    end
    chk("fence_err", fence_err, !acc);
    chk("fence_ok", fence_ok, &fmask);
    @(posedge clk); #1;
    chk("fence_err_pulse_end", fence_err, 0);
  endtask

  task automatic push_q(input int x, input int y, input int tag, input bit hang, input int dly, input int ins);
    q_t e;
    int n = 0;
    e.x = x; e.y = y; e.tag = tag; e.dly = dly; e.ins = ins; e.hang = hang;
    @(posedge clk); #1;
    q_valid = 1; q_x = CW'(x); q_y = CW'(y); q_tag = TW'(tag);
    while (!q_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 2000) chk("push_ready_timeout", 0, 1);
    exp_q.push_back(e);
    cfg_q.push_back(e);
    @(posedge clk); #1;
    q_valid = 0;
  endtask

  task automatic wait_core_low();
    int n = 0;
    while (core_reset && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("core_start", core_reset, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    r_ready = 0;
    forever begin
      @(posedge clk); #1;
      r_ready = hold ? 1'b0 : ($urandom_range(2) != 0);
    end
  end

  // core model: samples the stream, answers after a configured delay or never
  initial begin
    int cs = 0, gap = 0, exp_len = 0;
    bit had = 0;
    q_t cur;
    cur.x = 0; cur.y = 0; cur.tag = 0; cur.dly = 0; cur.ins = -1; cur.hang = 1;
    core_valid = 0; core_inside = 0;
    forever begin
      @(negedge clk);
      core_valid = 0;
      if (!rst_n) begin
        cs = 0; gap = 0; had = 0;
      end else if (core_reset) begin
        if (cs > 0) begin
          chk("core_low_len", cs, exp_len);
          had = 1; gap = 0; cs = 0;
        end
        gap++;
        core_valid = $urandom_range(3) == 0;
        core_inside = 1'($urandom_range(1));
      end else begin
        if (cs == 0) begin
          if (had) chk("core_gap_ge2", int'(gap >= 2), 1);
          if (cfg_q.size() == 0) chk("core_cfg_avail", 0, 1);
          else cur = cfg_q.pop_front();
          chk("stream_obj_x", core_x, cur.x);
          chk("stream_obj_y", core_y, cur.y);
          exp_len = 8 + (cur.hang ? TO + 1 : cur.dly + 1);
        end else if (cs < 7) begin
          chk("stream_vtx_x", core_x, fx[cs-1]);
          chk("stream_vtx_y", core_y, fy[cs-1]);
        end
        if (!cur.hang && cs == 8 + cur.dly) begin
          core_valid = 1;
          core_inside = pip(cur.x, cur.y);
        end
        cs++;
      end
    end
  end

  // result monitor: pops the scoreboard on each accepted result, checks hold stability
  initial begin
    bit pend = 0;
    int ptag = 0, pins = 0, ptmo = 0;
    q_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      else begin
        if (pend) begin
          chk("hold_r_valid", r_valid, 1);
          chk("hold_r_tag", r_tag, ptag);
          chk("hold_r_inside", r_inside, pins);
          chk("hold_r_timeout", r_timeout, ptmo);
        end
        if (r_valid) chk("core_reset_in_result", core_reset, 1);
        if (r_valid && r_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("r_tag", r_tag, e.tag);
            chk("r_inside", r_inside, e.hang ? 0 : (e.ins >= 0 ? e.ins : int'(pip(e.x, e.y))));
            chk("r_timeout", r_timeout, e.hang);
          end
        end
        pend = r_valid && !r_ready;
        ptag = r_tag; pins = r_inside; ptmo = r_timeout;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    rst_n = 0; fence_we = 0; fence_idx = 0; fence_x = 0; fence_y = 0;
    q_valid = 0; q_x = 0; q_y = 0; q_tag = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    @(negedge clk) rst_n = 1;
    wr_fence(7, 1, 1, 0);
    wr_fence(6, 2, 2, 0);
    for (int i = 0; i < 4; i++) begin
      push_q($urandom_range(0, 349), $urandom_range(0, 349), i, 0, $urandom_range(0, 5), -1);
      chk("q_ready_fill", q_ready, i < 3);
    end
    wr_fence(0, 100, 100, 1);
    wr_fence(1, 200, 100, 1);
    wr_fence(2, 250, 200, 1);
    wr_fence(3, 200, 300, 1);
    wr_fence(4, 100, 300, 1);
    wr_fence(5, 50, 200, 1);
    wait_core_low();
    wr_fence(0, 999, 999, 0);
    drain();
    push_q(150, 200, 3, 0, 2, 1);
    push_q(10, 10, 5, 0, 0, 0);
    drain();
    push_q(200, 200, 6, 1, 0, -1);
    push_q(150, 150, 7, 0, 1, -1);
    push_q(150, 250, 8, 0, TO, -1);
    drain();
    hold = 1;
    push_q(150, 200, 9, 0, 3, 1);
    begin
      int n = 0;
      while (!r_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (20) @(negedge clk);
    chk("hold_phase_valid", r_valid, 1);
    chk("hold_phase_core_reset", core_reset, 1);
    hold = 0;
    drain();
    for (int i = 0; i < 30; i++) begin
      bit h = $urandom_range(7) == 0;
      int d = ($urandom_range(5) == 0) ? TO : $urandom_range(0, 6);
      push_q($urandom_range(0, 349), $urandom_range(0, 349), $urandom_range(0, 15), h, d, -1);
    end
    drain();
    push_q(150, 200, 1, 0, 0, 1);
    wait_core_low();
    @(posedge clk); #1;
    rst_n = 0;
    #1 chk_reset_vals();
    exp_q.delete();
    cfg_q.delete();
    fmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    push_q(150, 200, 2, 0, 0, 1);
    repeat (10) begin
      @(negedge clk);
      chk("idle_without_fence", core_reset, 1);
    end
    chk("fence_lost", fence_ok, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
